lzx_74hc4511: RTL and testbench
===============================

LZX_74HC4511 -- requirements
Module: lzx_74hc4511

Interface
REQ-001 The block SHALL have exactly these ports, one per line: name  direction  width  meaning.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 BI_n  input  1  blanking input, active-low.
REQ-005 LT_n  input  1  lamp test input, active-low.
REQ-006 LE  input  1  latch enable: 0 = transparent, 1 = hold the stored BCD value.
REQ-007 D  input  4  BCD data in; D[3] is the MSB.
REQ-008 seg  output  7  segment drive, active-high; seg[0]=a, seg[1]=b, seg[2]=c, seg[3]=d, seg[4]=e, seg[5]=f, seg[6]=g.
REQ-009 The block SHALL have no parameters.

Function
REQ-010 The block SHALL hold a 4-bit BCD register, latch_q.
REQ-011 latch_q SHALL load D on a rising clk edge when LE=0.
REQ-012 latch_q SHALL hold its value on a rising clk edge when LE=1.
REQ-013 The decode source SHALL be D when LE=0 and latch_q when LE=1.
REQ-014 seg SHALL be a register updated on every rising clk edge, so output latency is one cycle from any input change.
REQ-015 When LT_n=0, next seg SHALL be 7'h7F (all segments on), regardless of BI_n, LE and D (highest priority).
REQ-016 When LT_n=1 and BI_n=0, next seg SHALL be 7'h00 (blank), regardless of LE and D.
REQ-017 When LT_n=1 and BI_n=1, next seg SHALL be the decode of the decode source, per REQ-018 to REQ-019.
REQ-018 Decode values, value->seg: 0->3F, 1->06, 2->5B, 3->4F, 4->66, 5->6D, 6->7C, 7->07, 8->7F, 9->67 (6 and 9 have no tails).
REQ-019 Codes 10 to 15 (A to F) SHALL decode to 7'h00 (blank); the block SHALL NOT display hex digits.
REQ-020 LT_n and BI_n SHALL NOT affect latch_q; latching SHALL continue while the display is tested or blanked.
REQ-021 Simultaneous LE rising and a D change in the same cycle: the edge on which LE is sampled 1 SHALL hold the previous latch_q, and D on that edge SHALL be ignored.
REQ-022 X/Z on any input SHALL NOT be required to be handled; the inputs are assumed to be driven to 0/1.

Reset
REQ-023 While rst=1 at a rising clk edge, latch_q SHALL become 4'h0 and seg SHALL become 7'h00, overriding all other inputs including LT_n=0.
REQ-024 On the first rising edge after rst deasserts, normal operation SHALL resume per REQ-011 to REQ-019.
REQ-025 Reset asserted mid-operation SHALL take effect at the next rising edge, with no partial update.

Verification
REQ-026 Lamp test and blanking:
- rst pulse, then BI_n=0, LT_n=1, LE=0, D=8 -> seg=00 one cycle later.
- Then BI_n=1, LT_n=0, D=0 -> seg=7F.
- BI_n=0 with LT_n=0 -> seg=7F.
REQ-027 Transparent decode: BI_n=1, LT_n=1, LE=0; D=0,1,5,8,9 each held several cycles -> seg=3F, 06, 6D, 7F, 67 respectively, each one cycle after D applied.
REQ-028 Invalid codes: D=A and D=F with LE=0 -> seg=00.
REQ-029 Latch hold:
- D=5, LE=0 -> seg=6D.
- Set LE=1, then D=2 -> seg stays 6D.
- LE=0 -> seg=5B next cycle.
REQ-030 Latch during blank: LE=0, BI_n=0, D=7; then LE=1, BI_n=1, D=3 -> seg=07.
REQ-031 Reset priority: LT_n=0 with rst=1 -> seg=00 while rst held; after rst=0 -> seg=7F next cycle.

Source files
------------

// File: rtl/lzx_74hc4511.sv
// lzx_74hc4511 -- clocked BCD-to-7-segment latch/decoder/driver.
//
// Synchronous model of the classic 4511. A 4-bit BCD latch captures D
// while LE=0 and holds it while LE=1. The decoder reads D directly while
// transparent and the stored value while latched. The segment outputs are
// registered, so every input change shows up one clock later.
//
// Output priority, highest first:
//   reset -> blank, lamp test (LT_n=0) -> all on, blank (BI_n=0) -> all off,
//   otherwise the decoded digit. Codes 10..15 decode to blank.
// Lamp test and blanking act only on the display. The latch keeps loading
// or holding underneath them.
//
// Segment order: seg[0]=a ... seg[6]=g, active-high.

module lzx_74hc4511 (
  input  logic       clk,
  input  logic       rst,
  input  logic       BI_n,
  input  logic       LT_n,
  input  logic       LE,
  input  logic [3:0] D,
  output logic [6:0] seg
);

  logic [3:0] r_latch_q;
  logic [6:0] r_seg;
  logic [3:0] w_src;
  logic [6:0] w_digit;
  logic [6:0] w_seg_next;

  // Decode source: live data while transparent, stored value while latched.
  // A cycle that raises LE and changes D together therefore holds the old value.
  always_comb begin
    w_src = LE ? r_latch_q : D;
  end

  // BCD to segment pattern. 6 and 9 are drawn without tails.
  // Codes 10..15 are not decimal digits and are blanked.
  always_comb begin
    w_digit = 7'h00;
    case (w_src)
      4'd0:    w_digit = 7'h3F;
      4'd1:    w_digit = 7'h06;
      4'd2:    w_digit = 7'h5B;
      4'd3:    w_digit = 7'h4F;
      4'd4:    w_digit = 7'h66;
      4'd5:    w_digit = 7'h6D;
      4'd6:    w_digit = 7'h7C;
      4'd7:    w_digit = 7'h07;
      4'd8:    w_digit = 7'h7F;
      4'd9:    w_digit = 7'h67;
      default: w_digit = 7'h00;
    endcase
  end

  // Display override priority: lamp test beats blanking, and blanking beats the digit.
  always_comb begin
    w_seg_next = w_digit;
    if (!LT_n) begin
      w_seg_next = 7'h7F;
    end else if (!BI_n) begin
      w_seg_next = 7'h00;
    end
  end

  // BCD latch: load when transparent and hold when latched. It ignores LT_n and BI_n.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_latch_q <= 4'h0;
    end else if (!LE) begin
      r_latch_q <= D;
    end
  end

  // Registered segment drive. Reset overrides everything, including lamp test.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= 7'h00;
    end else begin
      r_seg <= w_seg_next;
    end
  end

  assign seg = r_seg;

endmodule

// File: tb/tb_lzx_74hc4511.sv
// tb_lzx_74hc4511 -- directed test of the clocked 4511 decoder.
// Inputs change 1 time unit after a rising edge. The bench samples seg
// 1 time unit after the next rising edge, so each check sees the result
// of the inputs applied in the step before it.

module tb_lzx_74hc4511;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       BI_n;
  logic       LT_n;
  logic       LE;
  logic [3:0] D;
  logic [6:0] seg;

  always #5 clk = ~clk;

  lzx_74hc4511 dut (
    .clk  (clk),
    .rst  (rst),
    .BI_n (BI_n),
    .LT_n (LT_n),
    .LE   (LE),
    .D    (D),
    .seg  (seg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];

  // Hand-written 4511 decode table (a..g = bit0..bit6; 10..15 blank).
  logic [6:0] dec_tab [16];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic lt, input logic bi,
                       input logic le, input logic [3:0] d);
    rst  = r;
    LT_n = lt;
    BI_n = bi;
    LE   = le;
    D    = d;
  endtask

  // Advance one clock and leave the time 1 unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the inputs, clock once, then compare seg with the expected value.
  task automatic step(input string tag, input logic r, input logic lt,
                      input logic bi, input logic le, input logic [3:0] d,
                      input logic [6:0] exp_seg);
    logic [6:0] e;
    drive(r, lt, bi, le, d);
    exp_q.push_back(exp_seg);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    assert (seg === e) else begin
      n_errors++;
      $error("FAIL %s: seg=%h expected=%h", tag, seg, e);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    dec_tab[0]  = 7'h3F; dec_tab[1]  = 7'h06; dec_tab[2]  = 7'h5B; dec_tab[3]  = 7'h4F;
    dec_tab[4]  = 7'h66; dec_tab[5]  = 7'h6D; dec_tab[6]  = 7'h7C; dec_tab[7]  = 7'h07;
    dec_tab[8]  = 7'h7F; dec_tab[9]  = 7'h67; dec_tab[10] = 7'h00; dec_tab[11] = 7'h00;
    dec_tab[12] = 7'h00; dec_tab[13] = 7'h00; dec_tab[14] = 7'h00; dec_tab[15] = 7'h00;

    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);

    // Reset wins over lamp test; once reset is released, lamp test shows.
    step("rst_over_lt_a", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 7'h00);
    step("rst_over_lt_b", 1'b1, 1'b0, 1'b1, 1'b0, 4'h8, 7'h00);
    step("lt_after_rst",  1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 7'h7F);

    // Blanking and lamp test.
    step("blank_d8",      1'b0, 1'b1, 1'b0, 1'b0, 4'h8, 7'h00);
    step("lt_d0",         1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 7'h7F);
    step("lt_over_bi",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 7'h7F);

    // Transparent decode of every code, each held for two cycles.
    for (int v = 0; v < 16; v++) begin
      step($sformatf("dec_%0d_a", v), 1'b0, 1'b1, 1'b1, 1'b0, v[3:0], dec_tab[v]);
      step($sformatf("dec_%0d_b", v), 1'b0, 1'b1, 1'b1, 1'b0, v[3:0], dec_tab[v]);
    end

    // Latch hold: latch 5, then change D while held.
    step("hold_load5",    1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 7'h6D);
    step("hold_d2",       1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 7'h6D);
    step("hold_d8",       1'b0, 1'b1, 1'b1, 1'b1, 4'h8, 7'h6D);
    step("hold_release",  1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 7'h5B);

    // Raising LE and changing D in the same cycle keeps the old value.
    step("le_rise_load4", 1'b0, 1'b1, 1'b1, 1'b0, 4'h4, 7'h66);
    step("le_rise_d9",    1'b0, 1'b1, 1'b1, 1'b1, 4'h9, 7'h66);

    // Latching continues while blanked.
    step("blank_latch7",  1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 7'h00);
    step("show_latched7", 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 7'h07);

    // Latching continues while lamp test is active.
    step("lt_latch6",     1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 7'h7F);
    step("show_latched6", 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 7'h7C);

    // A latched invalid code stays blank.
    step("latch_a",       1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 7'h00);
    step("held_a",        1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 7'h00);

    // Mid-operation reset clears the latch; the held value then decodes as 0.
    step("mid_load9",     1'b0, 1'b1, 1'b1, 1'b0, 4'h9, 7'h67);
    step("mid_rst",       1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 7'h00);
    step("post_rst_hold", 1'b0, 1'b1, 1'b1, 1'b1, 4'h9, 7'h3F);
    step("post_rst_tr",   1'b0, 1'b1, 1'b1, 1'b0, 4'h3, 7'h4F);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
